// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and registered read data.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_prog #(
  parameter int D_WIDTH  = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     winc,
  input  logic [D_WIDTH-1:0]       wdata,
  input  logic                     rinc,
  input  logic                     clr,
  output logic [D_WIDTH-1:0]       rdata,
  output logic                     wfull,
  output logic                     rempty,
  output logic                     almost_full,
  output logic                     almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
`else
  output logic [$clog2(DEPTH):0]   count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE       = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW:0]        count_next;
  logic               wr_en;
  logic               rd_en;

  assign wr_en = winc && !wfull && !clr;
  assign rd_en = rinc && !rempty && !clr;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_next = count + ONE;
        2'b01:   count_next = count - ONE;
        default: count_next = count;
      endcase
    end
  end

  // Storage is deliberately left unreset; nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointers carry one extra bit and simply wrap modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rdata        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + ONE;
        if (rd_en) begin
          rd_ptr <= rd_ptr + ONE;
          rdata  <= mem[rd_ptr[AW-1:0]];
        end
      end
      count        <= count_next;
      wfull        <= (count_next == DEPTH_CNT);
      rempty       <= (count_next == '0);
      almost_full  <= (count_next >= AF_CNT);
      almost_empty <= (count_next <= AE_CNT);
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: stimulus queues hand-computed read data, a monitor checks rdata.
module tb_sync_fifo_prog;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int         checks = 0;
  int         errors = 0;
  int         rst_epoch = 0;
  logic [7:0] exp_q[$];

  sync_fifo_prog #(.D_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .clr(clr),
    .rdata(rdata), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .count(count), .overflow(overflow), .underflow(underflow)
`else
    .count(count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock of stimulus: drive at a falling edge, return at the next falling edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    winc = w; wdata = d; rinc = r; clr = c;
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; clr = 1'b0;
    $display("TXN w=%0b d=0x%02h r=%0b c=%0b -> count=%0d full=%0b empty=%0b", w, d, r, c, count, wfull, rempty);
  endtask

  // Monitor: a read accepted on a rising edge must present the queued word; otherwise rdata holds.
  logic       acc = 1'b0;
  int         seen_epoch = 0;
  logic [7:0] hold_val = 8'h00;
  logic [7:0] exp_val;

  always @(posedge clk) acc = rst_n && rinc && !rempty && !clr;

  always @(negedge clk) begin
    if (seen_epoch != rst_epoch) begin
      seen_epoch = rst_epoch;
      hold_val   = 8'h00;
    end
    if (acc) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=0x%02h required=no read", rdata);
      end else begin
        exp_val = exp_q.pop_front();
        chk("rd_data", rdata, exp_val);
        $display("RD rdata=0x%02h expected=0x%02h", rdata, exp_val);
        hold_val = exp_val;
      end
    end else begin
      chk("rd_hold", rdata, hold_val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    rst_epoch++;
    #1;
    chk("rst_count", count, 0);
    chk("rst_rempty", rempty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x00..0x0F, watching thresholds on the way up
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", count, i + 1);
      if (i + 1 == 1)  chk("fill_empty1", rempty, 0);
      if (i + 1 == 2)  chk("ae_at2", almost_empty, 1);
      if (i + 1 == 3)  chk("ae_at3", almost_empty, 0);
      if (i + 1 == 13) chk("af_at13", almost_full, 0);
      if (i + 1 == 14) chk("af_at14", almost_full, 1);
      if (i + 1 == 15) chk("full_at15", wfull, 0);
      if (i + 1 == 16) chk("full_at16", wfull, 1);
    end

    // Drain 16 words
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_count", count, 15 - i);
      if (15 - i == 13) chk("drain_af13", almost_full, 0);
      if (15 - i == 2)  chk("drain_ae2", almost_empty, 1);
    end
    chk("drain_empty", rempty, 1);
    chk("drain_full", wfull, 0);

    // Empty with write+read: write accepted, read rejected, rdata holds
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("empty_wr_rd_count", count, 1);
    chk("empty_wr_rd_rdata", rdata, 8'h0F);
    chk("empty_wr_rd_rempty", rempty, 0);
    exp_q.push_back(8'h55);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_wr_rd_drain", count, 0);

    // Full with write+read: read accepted, written word dropped
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("refill_count", count, 16);
    exp_q.push_back(8'h10);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("full_wr_rd_count", count, 15);
    chk("full_wr_rd_wfull", wfull, 0);
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(8'(8'h11 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("full_wr_rd_empty", rempty, 1);

    // Streaming at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(8'h80 + i));
      cyc(1'b1, 8'(8'h85 + i), 1'b1, 1'b0);
      chk("stream_count", count, 5);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'hA8 + i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("stream_drained", count, 0);

    // clr at count=9 overrides winc/rinc
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("pre_clr_count", count, 9);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("clr_count", count, 0);
    chk("clr_rempty", rempty, 1);
    chk("clr_ae", almost_empty, 1);
    chk("clr_af", almost_full, 0);
    chk("clr_wfull", wfull, 0);
    chk("clr_rdata", rdata, 8'hAC);
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    exp_q.push_back(8'h40);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_clr_count", count, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    exp_q.push_back(8'h60);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", count, 2);
    #2 rst_n = 1'b0;
    rst_epoch++;
    #1;
    chk("arst_count", count, 0);
    chk("arst_rempty", rempty, 1);
    chk("arst_wfull", wfull, 0);
    chk("arst_ae", almost_empty, 1);
    chk("arst_af", almost_full, 0);
    chk("arst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h70, 1'b0, 1'b0);
    exp_q.push_back(8'h70);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_count", count, 0);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("err_init_ov", overflow, 0);
    chk("err_init_un", underflow, 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("underflow_set", underflow, 1);
    chk("underflow_ov_clear", overflow, 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0);
    chk("overflow_set", overflow, 1);
    chk("overflow_count", count, 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("overflow_sticky", overflow, 1);
    chk("underflow_sticky", underflow, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ov", overflow, 0);
    chk("clr_un", underflow, 0);
    chk("clr_err_count", count, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
